// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_1rw1r_clr register-file store.
package ram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        READY
    } ram_state_t;

    // One byte lane of a masked write; the top loops this over all lanes.
    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       be
    );
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/ram_clr_fsm.sv
// Clear engine: walks every address writing zero after reset or on request.
module ram_clr_fsm
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    output logic              o_busy,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    ram_state_t        r_state;
    ram_state_t        w_state_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        o_clr_we     = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_next = CLEAR;
                w_cnt_next   = '0;
            end
            CLEAR: begin
                o_clr_we   = 1'b1;
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == '1) begin
                    w_state_next = READY;
                end
            end
            READY: begin
                if (i_clr) begin
                    w_state_next = CLEAR;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Decoded from the state register only, so BUSY has no input-to-output path.
    assign o_busy     = (r_state != READY);
    assign o_clr_addr = r_cnt;

endmodule

// File: rtl/ram_1rw1r_clr.sv
// 1RW + 1R register-file RAM with registered outputs and a hardware clear engine.
// Optional RAM_BYPASS_EN: forward a same-cycle port 0 write to a port 1 read of that address.
module ram_1rw1r_clr
    import ram_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned ADDR_W = 5,
    localparam int unsigned NB     = DATA_W / 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLR,
    output logic              BUSY,
    input  logic              EN0,
    input  logic [NB-1:0]     WE0,
    input  logic [ADDR_W-1:0] A0,
    input  logic [DATA_W-1:0] Di0,
    output logic [DATA_W-1:0] Do0,
    input  logic              EN1,
    input  logic [ADDR_W-1:0] A1,
    output logic [DATA_W-1:0] Do1
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_do0;
    logic [DATA_W-1:0] r_do1;

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_p0_act;
    logic              w_p1_act;
    logic [DATA_W-1:0] w_rd0;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_wr_word;

    ram_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .i_clk      (CLK),
        .i_rst_n    (RST_N),
        .i_clr      (CLR),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    assign w_p0_act = EN0 & ~w_busy;
    assign w_p1_act = EN1 & ~w_busy;
    assign w_rd0    = r_mem[A0];

    always_comb begin
        w_wr_word = w_rd0;
        for (int i = 0; i < int'(NB); i++) begin
            w_wr_word[8*i +: 8] = byte_merge(w_rd0[8*i +: 8], Di0[8*i +: 8], WE0[i]);
        end
    end

`ifdef RAM_BYPASS_EN
    assign w_rd1 = (w_p0_act && (|WE0) && (A0 == A1)) ? w_wr_word : r_mem[A1];
`else
    assign w_rd1 = r_mem[A1];
`endif

    // Array itself is never reset; the clear engine zeroes it instead.
    always_ff @(posedge CLK) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_p0_act && (|WE0)) begin
            r_mem[A0] <= w_wr_word;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_do0 <= '0;
            r_do1 <= '0;
        end else begin
            if (w_p0_act) begin
                r_do0 <= w_rd0;
            end
            if (w_p1_act) begin
                r_do1 <= w_rd1;
            end
        end
    end

    assign BUSY = w_busy;
    assign Do0  = r_do0;
    assign Do1  = r_do1;

endmodule

// File: tb/tb_ram_1rw1r_clr.sv
// Directed, table-driven bench for ram_1rw1r_clr (DATA_W=32, ADDR_W=5).
module tb_ram_1rw1r_clr;

    logic        CLK;
    logic        RST_N;
    logic        CLR;
    logic        BUSY;
    logic        EN0;
    logic [3:0]  WE0;
    logic [4:0]  A0;
    logic [31:0] Di0;
    logic [31:0] Do0;
    logic        EN1;
    logic [4:0]  A1;
    logic [31:0] Do1;

    int checks   = 0;
    int failures = 0;

`ifdef RAM_BYPASS_EN
    localparam logic [31:0] COLL_EXP = 32'hFF000000;
`else
    localparam logic [31:0] COLL_EXP = 32'h00000000;
`endif

    typedef struct {
        logic        en0;
        logic [3:0]  we0;
        logic [4:0]  a0;
        logic [31:0] di0;
        logic        en1;
        logic [4:0]  a1;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs[13];

    ram_1rw1r_clr #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CLR   (CLR),
        .BUSY  (BUSY),
        .EN0   (EN0),
        .WE0   (WE0),
        .A0    (A0),
        .Di0   (Di0),
        .Do0   (Do0),
        .EN1   (EN1),
        .A1    (A1),
        .Do1   (Do1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic vec_t mk(input logic en0, input logic [3:0] we0, input logic [4:0] a0,
                                input logic [31:0] di0, input logic en1, input logic [4:0] a1,
                                input logic [31:0] exp0, input logic [31:0] exp1);
        vec_t v;
        v.en0 = en0; v.we0 = we0; v.a0 = a0; v.di0 = di0;
        v.en1 = en1; v.a1 = a1; v.exp0 = exp0; v.exp1 = exp1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic en0, input logic [3:0] we0, input logic [4:0] a0,
                        input logic [31:0] di0, input logic en1, input logic [4:0] a1,
                        input logic clr);
        EN0 = en0; WE0 = we0; A0 = a0; Di0 = di0;
        EN1 = en1; A1 = a1; CLR = clr;
        @(posedge CLK);
        #1;
    endtask

    task automatic count_busy(input string name, input int exp);
        int n;
        n = 0;
        while (BUSY === 1'b1 && n < 200) begin
            n++;
            step(1'b0, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        end
        check(name, 32'(n), 32'(exp));
    endtask

    task automatic read_all_zero(input string name);
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 4'h0, 5'(i), 32'h0, 1'b1, 5'(31 - i), 1'b0);
            check({name, "_do0"}, Do0, 32'h0);
            check({name, "_do1"}, Do1, 32'h0);
        end
    endtask

    initial begin
        RST_N = 1'b0; CLR = 1'b0; EN0 = 1'b0; WE0 = 4'h0; A0 = 5'd0;
        Di0 = 32'h0; EN1 = 1'b0; A1 = 5'd0;

        vecs[0]  = mk(1, 4'h5, 5'd3, 32'hAABBCCDD, 1, 5'd0, 32'h00000000, 32'h00000000);
        vecs[1]  = mk(1, 4'h0, 5'd3, 32'h00000000, 1, 5'd3, 32'h00BB00DD, 32'h00BB00DD);
        vecs[2]  = mk(1, 4'hF, 5'd7, 32'h11111111, 0, 5'd0, 32'h00000000, 32'h00BB00DD);
        vecs[3]  = mk(1, 4'hF, 5'd7, 32'h22222222, 1, 5'd3, 32'h11111111, 32'h00BB00DD);
        vecs[4]  = mk(1, 4'h0, 5'd7, 32'h00000000, 1, 5'd7, 32'h22222222, 32'h22222222);
        vecs[5]  = mk(0, 4'hF, 5'd7, 32'h00000000, 0, 5'd9, 32'h22222222, 32'h22222222);
        vecs[6]  = mk(1, 4'h0, 5'd7, 32'h00000000, 1, 5'd9, 32'h22222222, 32'h00000000);
        vecs[7]  = mk(1, 4'h8, 5'd9, 32'hFFFFFFFF, 1, 5'd9, 32'h00000000, COLL_EXP);
        vecs[8]  = mk(1, 4'h0, 5'd9, 32'h00000000, 1, 5'd9, 32'hFF000000, 32'hFF000000);
        vecs[9]  = mk(1, 4'h0, 5'd9, 32'h12345678, 1, 5'd9, 32'hFF000000, 32'hFF000000);
        vecs[10] = mk(1, 4'hA, 5'd3, 32'h11223344, 1, 5'd9, 32'h00BB00DD, 32'hFF000000);
        vecs[11] = mk(1, 4'h0, 5'd3, 32'h00000000, 1, 5'd3, 32'h11BB33DD, 32'h11BB33DD);
        vecs[12] = mk(1, 4'h0, 5'd9, 32'h00000000, 0, 5'd3, 32'hFF000000, 32'h11BB33DD);

        // Reset state
        #3;
        check("rst_busy", 32'(BUSY), 32'h1);
        check("rst_do0", Do0, 32'h0);
        check("rst_do1", Do1, 32'h0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        count_busy("busy_after_reset", 33);
        read_all_zero("init_zero");

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].en0, vecs[i].we0, vecs[i].a0, vecs[i].di0,
                 vecs[i].en1, vecs[i].a1, 1'b0);
            check($sformatf("vec%0d_do0", i), Do0, vecs[i].exp0);
            check($sformatf("vec%0d_do1", i), Do1, vecs[i].exp1);
        end

        // Fill, then CLR alongside a port 0 access
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 4'hF, 5'(i), 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
        end
        step(1'b1, 4'hF, 5'd5, 32'hCAFEF00D, 1'b1, 5'd6, 1'b1);
        check("clr_cycle_do0", Do0, 32'hDEADBEEF);
        check("clr_cycle_do1", Do1, 32'hDEADBEEF);
        begin
            int n;
            n = 0;
            while (BUSY === 1'b1 && n < 200) begin
                n++;
                // Port traffic and a repeated CLR while busy must all be ignored.
                step(1'b1, 4'hF, 5'(n), 32'h00001234, 1'b1, 5'(n), (n == 5));
                if (BUSY === 1'b1) begin
                    check("busy_hold_do0", Do0, 32'hDEADBEEF);
                    check("busy_hold_do1", Do1, 32'hDEADBEEF);
                end
            end
            check("busy_after_clr", 32'(n), 32'd32);
        end
        read_all_zero("post_clr_zero");
        check("clr_not_queued", 32'(BUSY), 32'h0);

        // Reset in the middle of a clear
        step(1'b1, 4'hF, 5'd2, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
        step(1'b1, 4'h0, 5'd2, 32'h0, 1'b1, 5'd2, 1'b0);
        check("pre_rst_do0", Do0, 32'hDEADBEEF);
        check("pre_rst_do1", Do1, 32'hDEADBEEF);
        step(1'b0, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        repeat (10) step(1'b0, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        check("midrst_do0", Do0, 32'h0);
        check("midrst_do1", Do1, 32'h0);
        check("midrst_busy", 32'(BUSY), 32'h1);
        @(negedge CLK);
        RST_N = 1'b1;
        count_busy("busy_after_midrst", 33);
        read_all_zero("midrst_zero");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_1rw1r_clr.md
# ram_1rw1r_clr

Parametrised successor to the 32x32 single-port DFFRAM. It adds a second independent read port and registered outputs on both ports. A hardware clear engine zeroes the whole array after reset or on request, so simulation and silicon never rely on initial values. It sits beside the core as a general scratch / register-file store and is generic in width and depth.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W words
- NB (derived, not overridable), DATA_W/8, byte-lane count
- CLK  in  1  clock; all state on rising edge
- RST_N  in  1  reset, asynchronous assert, active-low
- CLR  in  1  single-cycle request to re-zero the array; sampled only in READY
- BUSY  out  1  high while the clear engine owns the array
- EN0  in  1  port 0 (read/write) enable
- WE0  in  NB  port 0 byte write enables; WE0[i] covers Di0[8i+7:8i]
- A0  in  ADDR_W  port 0 address
- Di0  in  DATA_W  port 0 write data
- Do0  out  DATA_W  port 0 registered read data
- EN1  in  1  port 1 (read-only) enable
- A1  in  ADDR_W  port 1 address
- Do1  out  DATA_W  port 1 registered read data

## Operation
- FSM states: IDLE, CLEAR, READY.
- RST_N low: state IDLE, clear counter 0, Do0 = Do1 = 0, BUSY = 1. Array contents are undefined until the clear finishes.
- IDLE -> CLEAR on the first edge after RST_N rises.
- CLEAR: one word is written with 0 per cycle at counter address 0..DEPTH-1. After DEPTH-1 is written, the FSM goes to READY. BUSY is 1 in IDLE and CLEAR.
- READY: BUSY = 0. CLR = 1 -> CLEAR, with the counter reset to 0. A port 0 access issued in the same cycle as CLR still completes.
- While BUSY, EN0 and EN1 are ignored: no array writes from port 0, and Do0/Do1 hold their value.
- Port 0 access (EN0 = 1, READY):
  - Do0 <= mem[A0] (old contents; read-before-write).
  - Each byte with WE0[i] = 1 is written from Di0.
  - WE0 = 0 is a pure read.
- Port 1 access (EN1 = 1, READY): Do1 <= mem[A1].
- EN low on either port: that port's Do holds its last value.
- Port 0 write and port 1 read to the same address in the same cycle: result per Configuration.
- Reset mid-CLEAR: returns to IDLE and the clear restarts from address 0 after release.
- CLR asserted while BUSY: ignored; it is not queued.

## Timing
- Read latency is 1 cycle on both ports: address at edge N, data valid after edge N.
- A write at edge N is visible to a read issued at edge N+1.
- Clear duration:
  - After reset: BUSY falls DEPTH+1 edges after RST_N release (1 IDLE cycle + DEPTH CLEAR cycles).
  - After CLR: DEPTH cycles.
- No combinational path from any input to Do0/Do1/BUSY.

## Configuration
- RAM_BYPASS_EN defined: on a same-cycle port 0 write and port 1 read to the same address, Do1 receives the merged word. Bytes with WE0[i] = 1 come from Di0; the others come from old mem.
- RAM_BYPASS_EN undefined: Do1 receives the old word. No forwarding logic is built.
- Port 0 behaviour is identical in both builds.

## Structure
- Package ram_pkg holds:
  - state enum ram_state_t {IDLE, CLEAR, READY}
  - function byte_merge(old, new, be), used by both the write path and the bypass
- Sub-module ram_clr_fsm holds the FSM, the ADDR_W-bit clear counter and BUSY. It exposes clr_we and clr_addr to the array wrapper.

## Test plan
- Reset release, DATA_W=32, ADDR_W=5 -> BUSY high for exactly 33 edges. All 32 addresses then read 0 on both ports.
- Write A0=3, WE0=4'b0101, Di0=32'hAABBCCDD onto zeros -> next read of addr 3 returns 32'h00BB00DD.
- Read-before-write: mem[7]=32'h11111111. Write Di0=32'h22222222, WE0=4'hF, A0=7 -> Do0 = 32'h11111111 that cycle, 32'h22222222 on the next read.
- Same-address collision: mem[9]=32'h0, write Di0=32'hFFFFFFFF with WE0=4'b1000 while A1=9, EN1=1. Do1 = 32'hFF000000 with RAM_BYPASS_EN, 32'h0 without.
- CLR in READY after writing all words 32'hDEADBEEF -> BUSY high for 32 cycles. Port accesses during BUSY leave Do0/Do1 unchanged. Afterwards all words read 0.
- RST_N pulsed low at clear counter 10 -> Do0 = Do1 = 0 immediately. The full 33-cycle clear repeats after release.
